// File: rtl/tone_synth_mc_pkg.sv
// Shared types and helpers for the multi-channel tone synthesiser.
// Note lookup holds half-period divisors for a 1 MHz clock.
package tone_pkg;

    localparam int NOTE_CNT      = 12;
    localparam int NOTE_REST_MIN = 12;

    localparam logic [15:0] NOTE_LUT [NOTE_CNT] = '{
        16'd30581, 16'd28864, 16'd27244, 16'd25715,
        16'd24272, 16'd22909, 16'd21624, 16'd20410,
        16'd19264, 16'd18183, 16'd17163, 16'd16199
    };

    typedef struct packed {
        logic [3:0] note;
        logic [3:0] oct;
        logic       glide;
    } cmd_t;

    function automatic logic [15:0] note_base(input logic [3:0] note);
        if (note >= 4'(NOTE_REST_MIN)) begin
            return 16'd0;
        end
        return NOTE_LUT[note];
    endfunction

    function automatic logic [3:0] clamp_oct(
        input logic [3:0] oct,
        input logic [3:0] oct_max
    );
        return (oct > oct_max) ? oct_max : oct;
    endfunction

endpackage

// File: rtl/tone_synth_mc_voice.sv
// One synthesiser voice: target/current divider, glide stepper,
// half-period toggle counter and registered tone/active outputs.
module tone_voice
    import tone_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [DIV_W-1:0] wr_div,
    input  logic             wr_glide,
    input  logic             glide_tick,
    output logic             tone,
    output logic             active,
    output logic [DIV_W-1:0] cur_div
);

    logic [DIV_W-1:0] target;
    logic [DIV_W-1:0] cur_nxt;
    logic [DIV_W-1:0] cnt;
    logic             jump;
    logic             wrap;

    always_comb begin
        cur_nxt = cur_div;
        jump    = !wr_glide || (wr_div == '0) || (cur_div == '0);
        if (wr_en) begin
            if (jump) begin
                cur_nxt = wr_div;
            end
        end else if (glide_tick && (cur_div != target)) begin
            if (target > cur_div) begin
                cur_nxt = cur_div + 1'b1;
            end else begin
                cur_nxt = cur_div - 1'b1;
            end
        end
    end

    // >= lets a divider that shrank below cnt wrap on the next cycle
    assign wrap = (cnt >= (cur_div - 1'b1));

    always_ff @(posedge clk) begin
        if (rst) begin
            target  <= '0;
            cur_div <= '0;
            cnt     <= '0;
            tone    <= 1'b0;
            active  <= 1'b0;
        end else begin
            cur_div <= cur_nxt;
            active  <= (cur_nxt != '0);
            if (wr_en) begin
                target <= wr_div;
            end
            if (cur_div == '0) begin
                cnt  <= '0;
                tone <= 1'b0;
            end else if (wrap) begin
                cnt  <= '0;
                tone <= ~tone;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tone_synth_mc.sv
// Multi-channel square-wave synthesiser: command handshake, two-stage
// note/octave divider pipeline, glide prescaler and NCH voices.
module tone_synth_mc
    import tone_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int DIV_W   = 16,
    parameter int GLIDE_W = 8,
    parameter int OCT_MAX = 8,
    localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CH_W-1:0]      cfg_ch,
    input  logic [3:0]           cfg_note,
    input  logic [3:0]           cfg_octave,
    input  logic                 cfg_glide,
    input  logic [GLIDE_W-1:0]   glide_rate,
    output logic [NCH-1:0]       tone_out,
    output logic [NCH-1:0]       active,
    output logic [NCH*DIV_W-1:0] cur_div
);

    localparam logic [DIV_W:0] ONE = {{DIV_W{1'b0}}, 1'b1};

    logic             busy;
    logic             accept;
    logic             s0_vld;
    logic             s1_vld;
    logic [CH_W-1:0]  s0_ch;
    cmd_t             s0_cmd;
    logic [CH_W-1:0]  s1_ch;
    logic [DIV_W-1:0] s1_base;
    logic [3:0]       s1_oct;
    logic             s1_glide;

    assign cfg_ready = !busy && !rst;
    assign accept    = cfg_valid && cfg_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            s0_vld   <= 1'b0;
            s1_vld   <= 1'b0;
            s0_ch    <= '0;
            s0_cmd   <= '0;
            s1_ch    <= '0;
            s1_base  <= '0;
            s1_oct   <= '0;
            s1_glide <= 1'b0;
        end else begin
            s0_vld <= accept;
            s1_vld <= s0_vld;
            if (accept) begin
                busy         <= 1'b1;
                s0_ch        <= cfg_ch;
                s0_cmd.note  <= cfg_note;
                s0_cmd.oct   <= cfg_octave;
                s0_cmd.glide <= cfg_glide;
            end else if (s1_vld) begin
                busy <= 1'b0;
            end
            if (s0_vld) begin
                s1_ch    <= s0_ch;
                s1_base  <= DIV_W'(note_base(s0_cmd.note));
                s1_oct   <= clamp_oct(s0_cmd.oct, 4'(OCT_MAX));
                s1_glide <= s0_cmd.glide;
            end
        end
    end

    // Rounded octave shift; one extra bit keeps the rounding add exact
    logic [DIV_W:0]   rnd;
    logic [DIV_W:0]   sum;
    logic [DIV_W:0]   quo;
    logic [DIV_W-1:0] wr_div;

    always_comb begin
        rnd = '0;
        if (s1_oct != 4'd0) begin
            rnd = ONE << (s1_oct - 4'd1);
        end
        sum    = {1'b0, s1_base} + rnd;
        quo    = sum >> s1_oct;
        wr_div = quo[DIV_W-1:0];
    end

    logic [GLIDE_W-1:0] pre;
    logic               glide_tick;

    assign glide_tick = (pre >= glide_rate);

    always_ff @(posedge clk) begin
        if (rst) begin
            pre <= '0;
        end else if (glide_tick) begin
            pre <= '0;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_voice
        logic wr_en;

        assign wr_en = s1_vld && (s1_ch == CH_W'(i));

        tone_voice #(
            .DIV_W(DIV_W)
        ) u_voice (
            .clk       (clk),
            .rst       (rst),
            .wr_en     (wr_en),
            .wr_div    (wr_div),
            .wr_glide  (s1_glide),
            .glide_tick(glide_tick),
            .tone      (tone_out[i]),
            .active    (active[i]),
            .cur_div   (cur_div[i*DIV_W +: DIV_W])
        );
    end

endmodule

// File: tb/tb_tone_synth_mc.sv
// Bench for tone_synth_mc: directed scenarios plus random commands,
// all cycles checked against a behavioural voice/command model.
module tb_tone_synth_mc;

    localparam int NCH     = 4;
    localparam int DIV_W   = 16;
    localparam int GLIDE_W = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [1:0]           cfg_ch;
    logic [3:0]           cfg_note;
    logic [3:0]           cfg_octave;
    logic                 cfg_glide;
    logic [GLIDE_W-1:0]   glide_rate;
    logic [NCH-1:0]       tone_out;
    logic [NCH-1:0]       active;
    logic [NCH*DIV_W-1:0] cur_div;

    always #5 clk = ~clk;

    tone_synth_mc #(
        .NCH(NCH), .DIV_W(DIV_W), .GLIDE_W(GLIDE_W), .OCT_MAX(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_note  (cfg_note),
        .cfg_octave(cfg_octave),
        .cfg_glide (cfg_glide),
        .glide_rate(glide_rate),
        .tone_out  (tone_out),
        .active    (active),
        .cur_div   (cur_div)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int lut [12] = '{30581, 28864, 27244, 25715, 24272, 22909,
                     21624, 20410, 19264, 18183, 17163, 16199};

    // model state
    int m_cur [NCH];
    int m_tgt [NCH];
    int m_cnt [NCH];
    bit m_tone [NCH];
    bit m_act [NCH];
    int m_pre;
    bit m_busy;
    int m_age;
    int m_ch;
    int m_d;
    bit m_g;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    // round-half-up of base / 2^oct, octave clamped to 8
    function automatic int exp_div(input int note, input int oct);
        int o;
        int b;
        if (note >= 12) return 0;
        o = (oct > 8) ? 8 : oct;
        b = lut[note];
        return (2 * b + (1 << o)) / (2 << o);
    endfunction

    function automatic int cur(input int ch);
        return int'(cur_div[ch*DIV_W +: DIV_W]);
    endfunction

    task automatic model_step();
        bit acc;
        bit wr;
        bit tick;
        int wch;
        int wd;
        bit wg;
        int c;
        if (rst) begin
            for (int v = 0; v < NCH; v++) begin
                m_cur[v] = 0; m_tgt[v] = 0; m_cnt[v] = 0;
                m_tone[v] = 0; m_act[v] = 0;
            end
            m_pre = 0; m_busy = 0; m_age = 0;
            return;
        end
        acc = cfg_valid && !m_busy;
        wr  = (m_age == 1);
        wch = m_ch; wd = m_d; wg = m_g;
        if (m_age > 0) m_age--;
        if (wr) m_busy = 0;
        if (acc) begin
            m_busy = 1;
            m_age  = 2;
            m_ch   = int'(cfg_ch);
            m_d    = exp_div(int'(cfg_note), int'(cfg_octave));
            m_g    = cfg_glide;
        end
        tick  = (m_pre >= int'(glide_rate));
        m_pre = tick ? 0 : m_pre + 1;
        for (int v = 0; v < NCH; v++) begin
            c = m_cur[v];
            if (c == 0) begin
                m_cnt[v] = 0; m_tone[v] = 0;
            end else if (m_cnt[v] >= c - 1) begin
                m_cnt[v] = 0; m_tone[v] = !m_tone[v];
            end else begin
                m_cnt[v]++;
            end
            if (wr && wch == v) begin
                m_tgt[v] = wd;
                if (!wg || wd == 0 || c == 0) m_cur[v] = wd;
            end else if (tick && c != m_tgt[v]) begin
                m_cur[v] = c + ((m_tgt[v] > c) ? 1 : -1);
            end
            m_act[v] = (m_cur[v] != 0);
        end
    endtask

    task automatic compare_all();
        logic [NCH-1:0]       et;
        logic [NCH-1:0]       ea;
        logic [NCH*DIV_W-1:0] ec;
        for (int v = 0; v < NCH; v++) begin
            et[v] = m_tone[v];
            ea[v] = m_act[v];
            ec[v*DIV_W +: DIV_W] = 16'(m_cur[v]);
        end
        check("ready", 64'(cfg_ready), 64'(!m_busy && !rst));
        check("tone", 64'(tone_out), 64'(et));
        check("active", 64'(active), 64'(ea));
        check("cur_div", 64'(cur_div), 64'(ec));
    endtask

    task automatic step_cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step_cycle();
    endtask

    task automatic send(input int ch, input int note, input int oct,
                        input bit g);
        bit acc;
        acc        = 0;
        cfg_valid  = 1'b1;
        cfg_ch     = 2'(ch);
        cfg_note   = 4'(note);
        cfg_octave = 4'(oct);
        cfg_glide  = g;
        for (int k = 0; k < 8 && !acc; k++) begin
            acc = cfg_ready;
            step_cycle();
        end
        cfg_valid = 1'b0;
        if (!acc) check("send_timeout", 64'(0), 64'(1));
    endtask

    task automatic measure(input int ch, output int n);
        logic prev;
        int   k;
        prev = tone_out[ch];
        k    = 0;
        while (tone_out[ch] == prev && k < 70000) begin
            step_cycle();
            k++;
        end
        prev = tone_out[ch];
        n    = 0;
        while (tone_out[ch] == prev && n < 70000) begin
            step_cycle();
            n++;
        end
    endtask

    initial begin
        int n;
        int mx;
        int w;
        int acc_cnt;
        logic p;

        rst = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_note = '0;
        cfg_octave = '0; cfg_glide = 1'b0; glide_rate = '0;

        steps(2);
        check("rst_ready", 64'(cfg_ready), 64'(0));
        check("rst_outs", 64'({tone_out, active, cur_div}), 64'(0));
        rst = 1'b0;
        step_cycle();
        check("rel_ready", 64'(cfg_ready), 64'(1));
        check("rel_tone_act", 64'({tone_out, active}), 64'(0));

        // note 9 oct 4, jump
        send(0, 9, 4, 0);
        check("busy_t0", 64'(cfg_ready), 64'(0));
        step_cycle();
        check("busy_t1", 64'(cfg_ready), 64'(0));
        check("pre_write", 64'(cur(0)), 64'(0));
        step_cycle();
        check("div_n9o4", 64'(cur(0)), 64'(1136));
        check("ready_t2", 64'(cfg_ready), 64'(1));
        check("active0", 64'(active[0]), 64'(1));
        measure(0, n);
        check("half_1136", 64'(n), 64'(1136));

        // rounding and clamp
        send(0, 0, 0, 0); steps(2);
        check("div_n0o0", 64'(cur(0)), 64'(30581));
        send(0, 0, 12, 0); steps(2);
        check("div_clamp", 64'(cur(0)), 64'(119));
        measure(0, n);
        check("half_119", 64'(2 * n), 64'(238));
        send(0, 13, 2, 0); steps(2);
        check("rest_div", 64'(cur(0)), 64'(0));
        check("rest_act", 64'(active[0]), 64'(0));
        step_cycle();
        check("rest_tone", 64'(tone_out[0]), 64'(0));

        // glide up 1911 -> 3823 at one step per 4 cycles
        glide_rate = 8'd3;
        send(1, 0, 4, 0); steps(2);
        check("glide_base", 64'(cur(1)), 64'(1911));
        send(1, 0, 3, 1); steps(2);
        check("glide_start", 64'(cur(1)), 64'(1911));
        n = 0; mx = 0;
        while (cur(1) != 3823 && n < 9000) begin
            step_cycle();
            n++;
            if (cur(1) > mx) mx = cur(1);
        end
        check("glide_time", 64'(n >= 7645 && n <= 7648), 64'(1));
        steps(20);
        if (cur(1) > mx) mx = cur(1);
        check("glide_hold", 64'(cur(1)), 64'(3823));
        check("no_overshoot", 64'(mx), 64'(3823));

        // retarget mid-glide reverses direction
        send(1, 0, 2, 1); steps(2);
        steps(200);
        send(1, 0, 4, 1); steps(2);
        w = cur(1);
        check("retgt_mid", 64'(w > 3823 && w < 7645), 64'(1));
        steps(100);
        check("retgt_dir", 64'(cur(1) < w), 64'(1));
        glide_rate = 8'd0;
        n = 0;
        while (cur(1) != 1911 && n < 8000) begin
            step_cycle();
            n++;
        end
        check("retgt_end", 64'(cur(1)), 64'(1911));

        // back-to-back with valid held on ch2/ch3
        steps(3);
        acc_cnt   = 0;
        cfg_valid = 1'b1;
        cfg_glide = 1'b0;
        for (int i = 0; i < 30; i++) begin
            cfg_ch     = 2'($urandom_range(2, 3));
            cfg_note   = 4'($urandom_range(0, 11));
            cfg_octave = 4'($urandom_range(0, 8));
            if (cfg_ready) acc_cnt++;
            step_cycle();
        end
        cfg_valid = 1'b0;
        check("b2b_accepts", 64'(acc_cnt), 64'(10));
        steps(3);

        // reset one cycle after accept drops the command
        rst = 1'b1; step_cycle(); rst = 1'b0; step_cycle();
        send(3, 5, 2, 0);
        rst = 1'b1; step_cycle(); rst = 1'b0;
        steps(4);
        check("rst_discard", 64'(cur(3)), 64'(0));

        // shrink divider below cnt wraps next cycle
        send(2, 0, 0, 0); steps(2);
        steps(200);
        send(2, 11, 8, 0); steps(2);
        check("div_small", 64'(cur(2)), 64'(63));
        p = tone_out[2];
        step_cycle();
        check("shrink_wrap", 64'(tone_out[2]), 64'(!p));
        measure(2, n);
        check("half_63", 64'(2 * n), 64'(126));

        // random commands against the model
        for (int i = 0; i < 3000; i++) begin
            cfg_valid  = 1'($urandom_range(0, 1));
            cfg_ch     = 2'($urandom_range(0, 3));
            cfg_note   = 4'($urandom_range(0, 15));
            cfg_octave = 4'($urandom_range(0, 15));
            cfg_glide  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) == 0) glide_rate = 8'($urandom_range(0, 3));
            rst = ($urandom_range(0, 299) == 0);
            step_cycle();
        end
        rst = 1'b0;
        cfg_valid = 1'b0;
        steps(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
